// File: rtl/slapfight_pkg.sv
// Shared types and default geometry for the slapfight work-RAM hiscore path.
package slapfight_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    GRANT,
    RD_WAIT,
    RELEASE
  } hs_state_e;

  localparam int          ADDR_W_DEF   = 11;
  localparam logic [15:0] RAM_BASE_DEF = 16'hC000;
  localparam int          HOLDOFF_DEF  = 16;

endpackage

// File: rtl/hiscore_ram_arbiter_window.sv
// Decodes a hiscore CPU-space address into a RAM offset and window hit.
module hs_addr_window
  import slapfight_pkg::*;
#(
  parameter int          ADDR_W = ADDR_W_DEF,
  parameter logic [15:0] BASE   = RAM_BASE_DEF
) (
  input  logic [15:0]       addr_i,
  output logic [ADDR_W-1:0] offset_o,
  output logic              in_window_o
);

  localparam logic [16:0] SIZE = 17'd1 << ADDR_W;

  logic [15:0] off;

  // 16-bit wrap: addresses below BASE land far outside the window
  assign off         = addr_i - BASE;
  assign offset_o    = off[ADDR_W-1:0];
  assign in_window_o = {1'b0, off} < SIZE;

endmodule

// File: rtl/hiscore_ram_arbiter.sv
// Work-RAM arbiter: CPU normally owns the RAM, hiscore engine borrows it
// only while the CPU is paused, with a CPU run interval between grants.
module hiscore_ram_arbiter
  import slapfight_pkg::*;
#(
  parameter int          ADDR_W   = ADDR_W_DEF,
  parameter logic [15:0] RAM_BASE = RAM_BASE_DEF,
  parameter int          HOLDOFF  = HOLDOFF_DEF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  input  logic              hs_req,
  input  logic [15:0]       hs_address,
  input  logic              hs_rd,
  input  logic              hs_write,
  input  logic [7:0]        hs_data_in,
  output logic [7:0]        hs_data_out,
  output logic              hs_rvalid,
  output logic              hs_grant,
  output logic              pause_req,
  input  logic              cpu_paused,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              conflict
);

  localparam int HW = $clog2(HOLDOFF + 1);

  hs_state_e         state_q;
  logic [HW-1:0]     hold_q;
  logic              rvalid_q;
  logic [7:0]        dout_q;
  logic              conflict_q;
  logic              rd_win_q;
  logic [ADDR_W-1:0] hs_off;
  logic              hs_win;

  hs_addr_window #(
    .ADDR_W (ADDR_W),
    .BASE   (RAM_BASE)
  ) u_win (
    .addr_i      (hs_address),
    .offset_o    (hs_off),
    .in_window_o (hs_win)
  );

  assign hs_grant  = (state_q == GRANT) || (state_q == RD_WAIT);
  assign pause_req = (state_q == DRAIN) || hs_grant;

  assign cpu_rdata   = ram_rdata;
  assign hs_data_out = dout_q;
  assign hs_rvalid   = rvalid_q;
  assign conflict    = conflict_q;

  always_comb begin
    ram_addr  = cpu_addr;
    ram_we    = cpu_cs & cpu_we;
    ram_wdata = cpu_wdata;
    if (hs_grant) begin
      ram_addr  = hs_off;
      ram_we    = (state_q == GRANT) & hs_write & hs_win;
      ram_wdata = hs_data_in;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      rvalid_q   <= 1'b0;
      dout_q     <= 8'h00;
      conflict_q <= 1'b0;
      rd_win_q   <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      if (cpu_cs && hs_grant)
        conflict_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (hold_q != '0)
            hold_q <= hold_q - HW'(1);
          else if (hs_req)
            state_q <= DRAIN;
        end
        DRAIN: begin
          if (!hs_req)
            state_q <= IDLE;
          else if (cpu_paused && !cpu_cs)
            state_q <= GRANT;
        end
        GRANT: begin
          // a write strobe wins and swallows a coincident read
          if (hs_write) begin
            state_q <= GRANT;
          end else if (hs_rd) begin
            rd_win_q <= hs_win;
            state_q  <= RD_WAIT;
          end else if (!hs_req) begin
            state_q <= RELEASE;
          end
        end
        RD_WAIT: begin
          dout_q   <= rd_win_q ? ram_rdata : 8'hFF;
          rvalid_q <= 1'b1;
          state_q  <= GRANT;
        end
        RELEASE: begin
          hold_q  <= HW'(HOLDOFF);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Directed bench for hiscore_ram_arbiter with a behavioural sync RAM.
module tb_hiscore_ram_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] cpu_addr;
  logic        cpu_cs;
  logic        cpu_we;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        hs_req;
  logic [15:0] hs_address;
  logic        hs_rd;
  logic        hs_write;
  logic [7:0]  hs_data_in;
  logic [7:0]  hs_data_out;
  logic        hs_rvalid;
  logic        hs_grant;
  logic        pause_req;
  logic        cpu_paused;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        conflict;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem [2048];

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  hiscore_ram_arbiter dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .cpu_addr    (cpu_addr),
    .cpu_cs      (cpu_cs),
    .cpu_we      (cpu_we),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .hs_req      (hs_req),
    .hs_address  (hs_address),
    .hs_rd       (hs_rd),
    .hs_write    (hs_write),
    .hs_data_in  (hs_data_in),
    .hs_data_out (hs_data_out),
    .hs_rvalid   (hs_rvalid),
    .hs_grant    (hs_grant),
    .pause_req   (pause_req),
    .cpu_paused  (cpu_paused),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .conflict    (conflict)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic hs_read(input logic [15:0] a, input logic [7:0] exp,
                         input string tag);
    hs_rd = 1'b1;
    hs_address = a;
    tick();
    hs_rd = 1'b0;
    chk({tag, "_wait_rv"}, hs_rvalid, 0);
    tick();
    chk({tag, "_rv"}, hs_rvalid, 1);
    chk({tag, "_data"}, hs_data_out, exp);
    tick();
  endtask

  initial begin
    int n;
    reset = 1'b1;
    cpu_addr = '0; cpu_cs = 0; cpu_we = 0; cpu_wdata = '0;
    hs_req = 0; hs_address = '0; hs_rd = 0; hs_write = 0;
    hs_data_in = '0; cpu_paused = 0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_grant", hs_grant, 0);
    chk("rst_pause", pause_req, 0);
    chk("rst_rvalid", hs_rvalid, 0);
    chk("rst_dout", hs_data_out, 8'h00);
    chk("rst_conflict", conflict, 0);

    // CPU preload through the idle mux
    cpu_addr = 11'h010; cpu_cs = 1; cpu_we = 1; cpu_wdata = 8'h5A;
    #1;
    chk("cpu_mux_addr", ram_addr, 11'h010);
    chk("cpu_mux_we", ram_we, 1);
    chk("cpu_mux_wdata", ram_wdata, 8'h5A);
    tick();
    cpu_cs = 0; cpu_we = 0;

    // basic read
    hs_req = 1;
    tick();
    chk("req_to_pause", pause_req, 1);
    chk("drain_no_grant", hs_grant, 0);
    tick(); tick();
    cpu_paused = 1;
    #1;
    chk("grant_lat0", hs_grant, 0);
    tick();
    chk("grant_lat1", hs_grant, 1);
    hs_rd = 1; hs_address = 16'hC010;
    #1;
    chk("rd_addr", ram_addr, 11'h010);
    chk("rd_no_we", ram_we, 0);
    tick();
    hs_rd = 0;
    chk("rdwait_rv", hs_rvalid, 0);
    chk("cpu_rdata", cpu_rdata, 8'h5A);
    tick();
    chk("rd_rv", hs_rvalid, 1);
    chk("rd_data", hs_data_out, 8'h5A);
    tick();
    chk("rv_pulse", hs_rvalid, 0);

    // write at top of window, then read back
    hs_write = 1; hs_address = 16'hC7FF; hs_data_in = 8'hA5;
    #1;
    chk("wr_we", ram_we, 1);
    chk("wr_addr", ram_addr, 11'h7FF);
    chk("wr_data", ram_wdata, 8'hA5);
    tick();
    hs_write = 0;
    hs_read(16'hC7FF, 8'hA5, "rb7ff");

    // window boundaries
    hs_write = 1; hs_address = 16'hC800; hs_data_in = 8'h77;
    #1;
    chk("oow_wr_we", ram_we, 0);
    tick();
    hs_write = 0;
    hs_read(16'hBFFF, 8'hFF, "oow_rd");

    // coincident read and write: write only
    hs_write = 1; hs_rd = 1; hs_address = 16'hC010; hs_data_in = 8'h3C;
    #1;
    chk("both_we", ram_we, 1);
    tick();
    hs_write = 0; hs_rd = 0;
    chk("both_grant", hs_grant, 1);
    tick();
    chk("both_no_rv", hs_rvalid, 0);
    tick();
    chk("both_no_rv2", hs_rvalid, 0);
    hs_read(16'hC010, 8'h3C, "both_rb");

    // CPU access while granted
    cpu_addr = 11'h010; cpu_cs = 1; cpu_we = 1; cpu_wdata = 8'hEE;
    #1;
    chk("cflt_we", ram_we, 0);
    tick();
    cpu_cs = 0; cpu_we = 0;
    chk("cflt_set", conflict, 1);
    hs_read(16'hC010, 8'h3C, "cflt_rb");

    // release and holdoff
    hs_req = 0;
    tick();
    chk("rel_grant", hs_grant, 0);
    chk("rel_pause", pause_req, 0);
    hs_req = 1; cpu_paused = 0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!pause_req && n < 40);
    chk("holdoff_rise", n, 18);
    chk("holdoff_pause", pause_req, 1);

    // drain abort: no grant, no holdoff
    hs_req = 0;
    tick();
    chk("abort_pause", pause_req, 0);
    chk("abort_grant", hs_grant, 0);
    hs_req = 1;
    tick();
    chk("abort_no_hold", pause_req, 1);
    chk("cflt_sticky", conflict, 1);

    // reset during RD_WAIT
    cpu_paused = 1;
    tick();
    chk("rg_grant", hs_grant, 1);
    hs_rd = 1; hs_address = 16'hC010;
    tick();
    hs_rd = 0;
    reset = 1;
    tick();
    reset = 0; hs_req = 0;
    chk("mr_grant", hs_grant, 0);
    chk("mr_pause", pause_req, 0);
    chk("mr_rvalid", hs_rvalid, 0);
    chk("mr_conflict", conflict, 0);
    tick();
    chk("mr_no_rv", hs_rvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
